// File: rtl/uart_prog_loader.sv
// Serial program loader: receives 8N1 bytes on rxd, assembles little-endian words
// and writes them into instruction memory while holding the CPU in reset.
module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF   = CLKS_PER_BIT / 2;
    localparam int unsigned LEN_W  = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [7:0]  SYNC_B = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM} fr_state_t;

    logic             rx_meta;
    logic             rx_s;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitcnt;
    logic [7:0]       shreg;
    logic             byte_vld;
    logic             frame_err;

    fr_state_t        fr_state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0] words_left;
    logic [1:0]       byte_idx;
    logic [31:0]      word;
    logic [7:0]       sum;

    // rxd is asynchronous; idle level is high so the synchronizer resets to 1
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    // UART byte receiver, samples mid-bit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_state  <= RX_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= RX_START;
                        cnt      <= '0;
                        bitcnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt      <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt    <= '0;
                        shreg  <= {rx_s, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt       <= '0;
                        byte_vld  <= rx_s;
                        frame_err <= !rx_s;
                        rx_state  <= RX_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Frame parser and memory writer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fr_state   <= WAIT_SYNC;
            addr       <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            word       <= '0;
            sum        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (frame_err && fr_state != WAIT_SYNC) begin
                err      <= 1'b1;
                cpu_hold <= 1'b0;
                fr_state <= WAIT_SYNC;
            end else if (byte_vld) begin
                case (fr_state)
                    WAIT_SYNC: begin
                        if (shreg == SYNC_B) begin
                            cpu_hold <= 1'b1;
                            done     <= 1'b0;
                            err      <= 1'b0;
                            addr     <= '0;
                            sum      <= '0;
                            fr_state <= GET_LEN;
                        end
                    end
                    GET_LEN: begin
                        // A length byte of zero selects the whole memory
                        words_left <= (shreg == 8'd0) ? LEN_W'(DEPTH) : LEN_W'(shreg);
                        byte_idx   <= '0;
                        fr_state   <= GET_DATA;
                    end
                    GET_DATA: begin
                        word     <= {shreg, word[31:8]};
                        sum      <= sum + shreg;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= addr;
                            mem_wdata  <= {shreg, word[31:8]};
                            addr       <= addr + ADDR_W'(1);
                            words_left <= words_left - LEN_W'(1);
                            if (words_left == LEN_W'(1)) begin
                                fr_state <= GET_SUM;
                            end
                        end
                    end
                    GET_SUM: begin
                        done     <= (shreg == sum);
                        err      <= (shreg != sum);
                        cpu_hold <= 1'b0;
                        fr_state <= WAIT_SYNC;
                    end
                    default: fr_state <= WAIT_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: bit-bangs 8N1 frames on rxd and checks
// memory writes and status outputs against hand-computed values.
module tb_uart_prog_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 8;

    logic          clk;
    logic          resetn;
    logic          rxd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] wq_addr[$];
    logic [31:0]   wq_data[$];
    int            we_double = 0;
    logic          we_prev   = 1'b0;
    logic [7:0]    fq[$];

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rxd       (rxd),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            if (we_prev) we_double++;
        end
        we_prev = mem_we;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_frame();
        while (fq.size() > 0) begin
            send_byte(fq.pop_front(), 1'b1);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic check_status(input string name, input logic e_hold,
                                input logic e_done, input logic e_err);
        checks++;
        if ({cpu_hold, done, err} !== {e_hold, e_done, e_err}) begin
            failures++;
            $display("FAIL %s: hold/done/err got %b%b%b want %b%b%b",
                     name, cpu_hold, done, err, e_hold, e_done, e_err);
        end
    endtask

    task automatic check_write(input string name, input int idx,
                               input logic [AW-1:0] e_addr, input logic [31:0] e_data);
        logic [AW-1:0] a;
        logic [31:0]   d;
        a = (idx < wq_addr.size()) ? wq_addr[idx] : 'x;
        d = (idx < wq_data.size()) ? wq_data[idx] : 'x;
        checks++;
        if (a !== e_addr || d !== e_data) begin
            failures++;
            $display("FAIL %s[%0d]: got addr=%h data=%h want addr=%h data=%h",
                     name, idx, a, d, e_addr, e_data);
        end
    endtask

    task automatic check_count(input string name, input int e_n);
        checks++;
        if (wq_addr.size() != e_n) begin
            failures++;
            $display("FAIL %s: write count got %0d want %0d", name, wq_addr.size(), e_n);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rxd    = 1'b1;
        settle(4);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== '0) begin
            failures++;
            $display("FAIL reset: we=%b addr=%h data=%h hold=%b done=%b err=%b want all 0",
                     mem_we, mem_addr, mem_wdata, cpu_hold, done, err);
        end
        resetn = 1'b1;
        settle(4);
        clear_writes();
    endtask

    task automatic test_basic_load();
        clear_writes();
        send_byte(8'hA5, 1'b1);
        settle(6);
        check_status("basic_hold_after_sync", 1'b1, 1'b0, 1'b0);
        fq = '{8'h02, 8'h33, 8'h00, 8'h00, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00};
        send_frame();
        settle(6);
        check_status("basic_hold_before_sum", 1'b1, 1'b0, 1'b0);
        send_byte(8'h56, 1'b1);
        settle(6);
        check_count("basic_count", 2);
        check_write("basic_w", 0, 8'h00, 32'h0000_0033);
        check_write("basic_w", 1, 8'h01, 32'h0010_8093);
        check_status("basic_done", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_bad_checksum();
        clear_writes();
        fq = '{8'hA5, 8'h02, 8'h33, 8'h00, 8'h00, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00, 8'h00};
        send_frame();
        settle(6);
        check_count("badsum_count", 2);
        check_write("badsum_w", 0, 8'h00, 32'h0000_0033);
        check_write("badsum_w", 1, 8'h01, 32'h0010_8093);
        check_status("badsum_err", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_framing_error();
        clear_writes();
        fq = '{8'hA5, 8'h01, 8'h11};
        send_frame();
        send_byte(8'h22, 1'b0);
        settle(60);
        check_count("framing_no_write", 0);
        check_status("framing_err", 1'b0, 1'b0, 1'b1);
        fq = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        send_frame();
        settle(6);
        check_count("framing_recover_count", 1);
        check_write("framing_recover_w", 0, 8'h00, 32'h1234_5678);
        check_status("framing_recover_done", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_noise_junk();
        clear_writes();
        rxd = 1'b0;
        settle(1);
        rxd = 1'b1;
        settle(20);
        fq = '{8'h00, 8'hFF};
        send_frame();
        settle(6);
        check_status("noise_junk_ignored", 1'b0, 1'b1, 1'b0);
        fq = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        send_frame();
        settle(6);
        check_count("noise_count", 1);
        check_write("noise_w", 0, 8'h00, 32'h0403_0201);
        check_status("noise_done", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        int bad;
        clear_writes();
        fq = '{8'hA5, 8'h00};
        send_frame();
        for (int n = 0; n < 256; n++) begin
            send_byte(8'(n), 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h00, 1'b1);
        end
        settle(6);
        check_status("wrap_hold_before_sum", 1'b1, 1'b0, 1'b0);
        send_byte(8'h80, 1'b1);
        settle(6);
        check_count("wrap_count", 256);
        bad = 0;
        for (int n = 0; n < 256; n++) begin
            checks++;
            if (n >= wq_addr.size() || wq_addr[n] !== 8'(n) || wq_data[n] !== 32'(n)) begin
                failures++;
                bad++;
                if (bad <= 4)
                    $display("FAIL wrap_w[%0d]: got addr=%h data=%h want addr=%h data=%h",
                             n, (n < wq_addr.size()) ? wq_addr[n] : 8'hxx,
                             (n < wq_data.size()) ? wq_data[n] : 32'hx, 8'(n), 32'(n));
            end
        end
        check_status("wrap_done", 1'b0, 1'b1, 1'b0);
        checks++;
        if (we_double != 0) begin
            failures++;
            $display("FAIL we_pulse_width: back-to-back mem_we cycles got %0d want 0", we_double);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_writes();
        fq = '{8'hA5, 8'h01, 8'h11, 8'h22};
        send_frame();
        settle(6);
        check_status("rstmid_hold_before", 1'b1, 1'b0, 1'b0);
        resetn = 1'b0;
        settle(1);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: we=%b addr=%h data=%h hold=%b done=%b err=%b want all 0",
                     mem_we, mem_addr, mem_wdata, cpu_hold, done, err);
        end
        settle(2);
        resetn = 1'b1;
        settle(4);
        check_count("rstmid_no_partial", 0);
        fq = '{8'hA5, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
        send_frame();
        settle(6);
        check_count("rstmid_fresh_count", 1);
        check_write("rstmid_fresh_w", 0, 8'h00, 32'hDDCC_BBAA);
        check_status("rstmid_fresh_done", 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        rxd    = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_load();
        test_bad_checksum();
        test_framing_error();
        test_noise_junk();
        test_wrap();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
